// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI mode-0 slave: default word width and mode bits.
package spi_slave_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam bit          SPI_CPOL   = 1'b0;
   localparam bit          SPI_CPHA   = 1'b0;

endpackage

// File: rtl/spi_slave_core_if.sv
// SPI pin bundle between an external master and the slave core.
interface spi_slave_core_if;

   logic sclk;
   logic mosi;
   logic miso;
   logic ss_n;

   modport master (output sclk, output mosi, output ss_n, input miso);
   modport slave  (input sclk, input mosi, input ss_n, output miso);

endinterface

// File: rtl/spi_sync_2ff.sv
// Two-flop synchronizer with configurable reset value; both stages are exported.
module spi_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic s1_o,
   output logic s2_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign s1_o = s1_q;
   assign s2_o = s2_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave core: sclk-domain rx/tx shifters, clk-domain word hand-off.
// Optional rx_valid pulse output when SPI_SLAVE_RX_VALID_EN is defined.
module spi_slave_core
   import spi_slave_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_slave_core_if.slave   spi,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
`ifdef SPI_SLAVE_RX_VALID_EN
   ,
   output logic              rx_valid
`endif
);

   logic [DATA_W-1:0] rx_shift_q;
   logic [DATA_W-1:0] tx_shift_q;
   logic [DATA_W-1:0] tx_shift_d;
   logic              tx_run_q;
   logic              tx_clr;
   logic              ss_s1;
   logic              ss_s2;
   logic              ss_rise;
   logic [DATA_W-1:0] data_out_q;
   logic [DATA_W-1:0] data_out_d;

   always_ff @(posedge spi.sclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift_q <= '0;
      end else if (!spi.ss_n) begin
         rx_shift_q <= {rx_shift_q[DATA_W-2:0], spi.mosi};
      end
   end

   // The idle-time level load is folded into the first falling edge: until then
   // miso reads data_in directly, so no asynchronously loaded data flops are needed.
   assign tx_clr = spi.ss_n | ~rst_n;

   always_comb begin
      tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
      if (!tx_run_q) begin
         tx_shift_d = {data_in[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(negedge spi.sclk or posedge tx_clr) begin
      if (tx_clr) begin
         tx_shift_q <= '0;
         tx_run_q   <= 1'b0;
      end else begin
         tx_shift_q <= tx_shift_d;
         tx_run_q   <= 1'b1;
      end
   end

   assign spi.miso = tx_clr   ? 1'b0 :
                     tx_run_q ? tx_shift_q[DATA_W-1] : data_in[DATA_W-1];

   spi_sync_2ff #(
      .RST_VAL (1'b1)
   ) u_ss_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (spi.ss_n),
      .s1_o  (ss_s1),
      .s2_o  (ss_s2)
   );

   assign ss_rise = ss_s1 & ~ss_s2;

   always_comb begin
      data_out_d = data_out_q;
      if (ss_rise) begin
         data_out_d = rx_shift_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

`ifdef SPI_SLAVE_RX_VALID_EN
   logic rx_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= ss_rise;
      end
   end

   assign rx_valid = rx_valid_q;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Randomized self-checking bench for spi_slave_core against a word-level model.
module tb_spi_slave_core;

   localparam int unsigned W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
`ifdef SPI_SLAVE_RX_VALID_EN
   logic         rx_valid;
`endif

   spi_slave_core_if spi ();

   spi_slave_core #(
      .DATA_W (W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi      (spi),
      .data_in  (data_in),
      .data_out (data_out)
`ifdef SPI_SLAVE_RX_VALID_EN
      ,
      .rx_valid (rx_valid)
`endif
   );

   always #5 clk = ~clk;

   int unsigned  checks = 0;
   int unsigned  errors = 0;

   // Model state written by the stimulus: received word and the snapshot taken at ss_n rise.
   logic [W-1:0] rx_m     = '0;
   logic [W-1:0] pend_val = '0;
   int unsigned  rise_seq = 0;

   // Model state written by the timing process: what data_out/rx_valid must show.
   logic [W-1:0] exp_out   = '0;
   logic         exp_valid = 1'b0;
   int unsigned  seen_seq  = 0;
   int unsigned  pend_cnt  = 0;

   // data_out takes the snapshot on the second clk edge after ss_n rises.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_out   = '0;
         exp_valid = 1'b0;
         pend_cnt  = 0;
         seen_seq  = rise_seq;
      end else begin
         exp_valid = 1'b0;
         if (rise_seq != seen_seq) begin
            seen_seq = rise_seq;
            pend_cnt = 2;
         end
         if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
               exp_out   = pend_val;
               exp_valid = 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One master transaction of n bits (MSB of the n-bit field first); abort_at>0 pulses reset after that bit.
   task automatic frame(input logic [15:0] bits, input int unsigned n, input int unsigned abort_at,
                        output logic [W-1:0] rd);
      logic [W-1:0] word;
      logic         b;
      logic         exp_bit;
      rd   = '0;
      word = data_in;
      @(negedge clk);
      spi.ss_n = 1'b0;
      #1;
      check("miso_first", spi.miso, word[W-1]);
      #1;
      for (int unsigned i = 0; i < n; i++) begin
         b        = bits[n-1-i];
         spi.mosi = b;
         #5;
         spi.sclk = 1'b1;
         #1;
         exp_bit = (i < W) ? word[W-1-i] : 1'b0;
         check("miso_bit", spi.miso, exp_bit);
         if (i < W) rd = {rd[W-2:0], spi.miso};
         rx_m = {rx_m[W-2:0], b};
         if (abort_at == i + 1) begin
            rst_n    = 1'b0;
            rx_m     = '0;
            spi.sclk = 1'b0;
            spi.ss_n = 1'b1;
            #20;
            check("miso_in_reset", spi.miso, 1'b0);
            check("dout_in_reset", data_out, '0);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            return;
         end
         #4;
         spi.sclk = 1'b0;
         if (i == 1) data_in = W'($urandom);
      end
      #5;
      @(negedge clk);
      spi.ss_n = 1'b1;
      pend_val = rx_m;
      rise_seq = rise_seq + 1;
      #1;
      check("miso_idle", spi.miso, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic stimulus();
      logic [W-1:0] rd;
      int unsigned  n;
      data_in = 8'h5A;
      frame(16'h003C, 8, 0, rd);
      check("lit_dout_3C", data_out, 8'h3C);
      check("lit_miso_5A", rd, 8'h5A);
      frame(16'h00AA, 8, 0, rd);
      check("lit_dout_AA", data_out, 8'hAA);
      data_in = 8'h5A;
      frame(16'h0055, 8, 0, rd);
      check("lit_dout_55", data_out, 8'h55);
      data_in = 8'h5A;
      frame(16'h0F3C, 12, 0, rd);
      check("lit_dout_F3C", data_out, 8'h3C);
      check("lit_miso_12b", rd, 8'h5A);
      frame(16'h000F, 8, 4, rd);
      check("lit_dout_abort", data_out, 8'h00);
      frame(16'h0081, 8, 0, rd);
      check("lit_dout_81", data_out, 8'h81);
      frame(16'h0000, 0, 0, rd);
      check("lit_dout_nosclk", data_out, 8'h81);
      frame(16'h0003, 4, 0, rd);
      check("lit_dout_short", data_out, 8'h13);
      for (int k = 0; k < 40; k++) begin
         data_in = W'($urandom);
         n       = $urandom_range(0, 12);
         frame(16'($urandom), n, (k % 13 == 5) ? $urandom_range(1, 3) : 0, rd);
      end
   endtask

   initial begin
      spi.ss_n = 1'b1;
      spi.sclk = 1'b0;
      spi.mosi = 1'b0;
      data_in  = '0;
      #20;
      check("rst_miso", spi.miso, 1'b0);
      check("rst_dout", data_out, 8'h00);
`ifdef SPI_SLAVE_RX_VALID_EN
      check("rst_rx_valid", rx_valid, 1'b0);
`endif
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_dout", data_out, 8'h00);
      fork
         forever begin
            @(negedge clk);
            check("data_out", data_out, exp_out);
`ifdef SPI_SLAVE_RX_VALID_EN
            check("rx_valid", rx_valid, exp_valid);
`endif
         end
         stimulus();
      join_any
      disable fork;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
